bcd_output_unit: RTL and testbench

//   Output-side partner of the input unit's BCD range check. Converts an 8-bit
//   two's-complement calculator result into the 16-bit sign+3-digit BCD word

---
 rtl/bcd_output_unit.sv | 131 +++++++++++++
 tb/tb_bcd_output_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_output_unit.sv
// Signed 8-bit to sign + 3-digit BCD converter (sequential double-dabble).
// Optional leading-zero blanking: define LEADING_BLANK_EN.
module bcd_output_unit #(
    parameter logic [3:0] NEG_CODE   = 4'd14,
    parameter logic [3:0] BLANK_CODE = 4'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out
);

`ifdef LEADING_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FIN
    } state_t;

    state_t      state_q, state_d;
    logic        neg_q, neg_d;
    logic [7:0]  mag_q, mag_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] bcd_out_q, bcd_out_d;

    logic [11:0] adj;
    logic [3:0]  hund_w, tens_w, ones_w, sign_w;

    always_comb begin
        adj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        adj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        adj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
    end

    // Tens is only darkened when hundreds is also zero; ones always shows.
    always_comb begin
        ones_w = bcd_q[3:0];
        tens_w = bcd_q[7:4];
        hund_w = bcd_q[11:8];
        sign_w = neg_q ? NEG_CODE : 4'h0;
        if (BLANK_EN) begin
            if (bcd_q[11:8] == 4'd0) begin
                hund_w = BLANK_CODE;
                if (bcd_q[7:4] == 4'd0) begin
                    tens_w = BLANK_CODE;
                end
            end
            if (!neg_q) begin
                sign_w = BLANK_CODE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_out_d = bcd_out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    neg_d   = bin_in[7];
                    mag_d   = bin_in[7] ? (~bin_in + 8'd1) : bin_in;
                    bcd_d   = 12'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, mag_d} = {adj[10:0], mag_q, 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bcd_out_d = {sign_w, hund_w, tens_w, ones_w};
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            neg_q     <= 1'b0;
            mag_q     <= 8'd0;
            bcd_q     <= 12'd0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_out_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            neg_q     <= neg_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_out_q <= bcd_out_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_out_q;

endmodule

// File: tb/tb_bcd_output_unit.sv
// Directed bench for bcd_output_unit: latency, sign/boundary values,
// busy-start rejection, mid-conversion reset and back-to-back throughput.
module tb_bcd_output_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;

    int total;
    int bad;

    bcd_output_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; returns number of edges seen (0 on timeout).
    task automatic wait_done(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_conv(input logic [7:0] v, input logic [15:0] exp_w,
                            input string name);
        int n;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = 8'h5A;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_accept got=%b want=1", name, busy);
        end
        wait_done(20, n);
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL %s latency got=%0d want=9", name, n);
        end
        total++;
        if (bcd_out !== exp_w || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s word got=%h busy=%b want=%h busy=0",
                     name, bcd_out, busy, exp_w);
        end
        tick();
        total++;
        if (done !== 1'b0 || bcd_out !== exp_w) begin
            bad++;
            $display("FAIL %s done_pulse done=%b word=%h want done=0 word=%h",
                     name, done, bcd_out, exp_w);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
            bad++;
            $display("FAIL reset busy=%b done=%b word=%h want 0 0 0000",
                     busy, done, bcd_out);
        end
        tick();
    endtask

    task automatic test_values();
`ifdef LEADING_BLANK_EN
        run_conv(8'd127, 16'hF127, "pos127");
        run_conv(8'h80,  16'hE128, "neg128");
        run_conv(8'hFF,  16'hEFF1, "neg1");
        run_conv(8'd0,   16'hFFF0, "zero");
        run_conv(8'd100, 16'hF100, "pos100");
        run_conv(8'd9,   16'hFFF9, "pos9");
        run_conv(8'd10,  16'hFF10, "pos10");
`else
        run_conv(8'd127, 16'h0127, "pos127");
        run_conv(8'h80,  16'hE128, "neg128");
        run_conv(8'hFF,  16'hE001, "neg1");
        run_conv(8'd0,   16'h0000, "zero");
        run_conv(8'd100, 16'h0100, "pos100");
        run_conv(8'd9,   16'h0009, "pos9");
        run_conv(8'd10,  16'h0010, "pos10");
`endif
    endtask

    task automatic test_start_while_busy();
        int n;
        int dones;
        logic [15:0] exp_w;
`ifdef LEADING_BLANK_EN
        exp_w = 16'hFF45;
`else
        exp_w = 16'h0045;
`endif
        bin_in = 8'd45;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        bin_in = 8'd99;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, n);
        total++;
        if (n != 6 || bcd_out !== exp_w) begin
            bad++;
            $display("FAIL busy_start edges=%0d word=%h want edges=6 word=%h",
                     n, bcd_out, exp_w);
        end
        dones = 0;
        repeat (20) begin
            tick();
            if (done) dones++;
        end
        total++;
        if (dones != 0 || bcd_out !== exp_w) begin
            bad++;
            $display("FAIL busy_start_extra dones=%0d word=%h want 0 %h",
                     dones, bcd_out, exp_w);
        end
    endtask

    task automatic test_reset_midconv();
        int dones;
        logic [15:0] exp_w;
`ifdef LEADING_BLANK_EN
        exp_w = 16'hEF10;
`else
        exp_w = 16'hE010;
`endif
        bin_in = 8'd99;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
            bad++;
            $display("FAIL midreset busy=%b done=%b word=%h want 0 0 0000",
                     busy, done, bcd_out);
        end
        dones = 0;
        repeat (15) begin
            tick();
            if (done) dones++;
        end
        total++;
        if (dones != 0 || bcd_out !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_nodone dones=%0d word=%h want 0 0000",
                     dones, bcd_out);
        end
        run_conv(8'hF6, exp_w, "neg10");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals [3];
        logic [15:0] exps [3];
        int n;
        vals[0] = 8'd12;
        vals[1] = 8'hC0;
        vals[2] = 8'd127;
`ifdef LEADING_BLANK_EN
        exps[0] = 16'hFF12;
        exps[1] = 16'hEF64;
        exps[2] = 16'hF127;
`else
        exps[0] = 16'h0012;
        exps[1] = 16'hE064;
        exps[2] = 16'h0127;
`endif
        bin_in = vals[0];
        start  = 1'b1;
        tick();
        bin_in = 8'h33;
        for (int k = 0; k < 3; k++) begin
            wait_done(20, n);
            total++;
            if (n != 9 || bcd_out !== exps[k]) begin
                bad++;
                $display("FAIL b2b_%0d edges=%0d word=%h want edges=9 word=%h",
                         k, n, bcd_out, exps[k]);
            end
            if (k < 2) begin
                bin_in = vals[k+1];
                tick();
                total++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_accept_%0d done=%b busy=%b want 0 1",
                             k, done, busy);
                end
                bin_in = 8'h33;
            end else begin
                start = 1'b0;
            end
        end
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_values();
        test_start_while_busy();
        test_reset_midconv();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
